// File: rtl/vedic_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2-bit Vedic digit product per
// cycle, shifted and accumulated into a 2*WIDTH-bit result.

module Vedic_2bit_Mul (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] Res
);
  logic p00, p01, p10, p11, c1;

  assign p00 = A[0] & B[0];
  assign p01 = A[0] & B[1];
  assign p10 = A[1] & B[0];
  assign p11 = A[1] & B[1];
  assign c1  = p10 & p01;

  assign Res[0] = p00;
  assign Res[1] = p10 ^ p01;
  assign Res[2] = p11 ^ c1;
  assign Res[3] = p11 & c1;
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; IN_READY and OUT_VALID come straight from the state register.
module vedic_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   OP_A,
  input  logic [WIDTH-1:0]   OP_B,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [1:0]         dbg_state
);
  localparam int N  = WIDTH / 2;
  localparam int NN = N * N;
  localparam int PW = 2 * WIDTH;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("vedic_seq_mul: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc, acc_next, term;
  logic [KW-1:0]    k;
  logic [1:0]       a_dig, b_dig;
  logic [3:0]       res;
  logic             last;
  int               ii, jj;

  Vedic_2bit_Mul u_mul (
    .A   (a_dig),
    .B   (b_dig),
    .Res (res)
  );

  // Step k walks B digits fastest: i = k / N selects the A digit, j = k mod N the B digit.
  always_comb begin
    ii       = int'(k) / N;
    jj       = int'(k) % N;
    a_dig    = 2'(a_reg >> (2 * ii));
    b_dig    = 2'(b_reg >> (2 * jj));
    term     = PW'(res) << (2 * (ii + jj));
    acc_next = acc + term;
    last     = (k == KW'(NN - 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (IN_VALID)  state_next = S_MUL;
      S_MUL:   if (last)      state_next = S_DONE;
      S_DONE:  if (OUT_READY) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      k       <= '0;
      PRODUCT <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            a_reg <= OP_A;
            b_reg <= OP_B;
            acc   <= '0;
            k     <= '0;
          end
        end
        S_MUL: begin
          acc <= acc_next;
          k   <= k + KW'(1);
          // PRODUCT is written only here, so it holds the previous result until now.
          if (last) PRODUCT <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state == S_IDLE);
  assign OUT_VALID = (state == S_DONE);
  assign dbg_state = state;
endmodule
